iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/scc_pkg.sv | 7 +
 rtl/muldiv_step.sv | 20 ++
 rtl/iter_muldiv.sv | 84 ++++++++
 tb/tb_iter_muldiv.sv | 138 +++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// scc_pkg: shared op/state encodings and default widths for the iterative mul/div unit
package scc_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF = 3;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_UDIV = 2'b01, OP_UREM = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring-divide step
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] x_n,
  output logic [WIDTH-1:0] y_n,
  output logic [WIDTH-1:0] acc_n
);
  logic [WIDTH:0] r, diff;
  // remainder stays below the divisor, so diff's top bit is a clean borrow flag
  assign r = {acc, x[WIDTH-1]};
  assign diff = r - {1'b0, y};
  assign x_n = div ? {x[WIDTH-2:0], ~diff[WIDTH]} : x << 1;
  assign y_n = div ? y : y >> 1;
  assign acc_n = div ? (diff[WIDTH] ? r[WIDTH-1:0] : diff[WIDTH-1:0]) : (y[0] ? acc + x : acc);
endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: 32-cycle iterative unsigned multiply / divide / remainder with register-file writeback
module iter_muldiv
  import scc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [AW-1:0]    dest_addr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    wb_addr,
  output logic             wb_enable,
  output logic             div_by_zero
);
  state_e state_q, state_d;
  op_e op_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q, x_n, y_n, acc_n, result_q, fin;
  logic [4:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic dbz_q, accept, last;

  assign accept = state_q == S_IDLE && start;
  assign last = state_q == S_RUN && cnt_q == 5'd31;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div(op_q != OP_MUL), .x(x_q), .y(y_q), .acc(acc_q),
    .x_n(x_n), .y_n(y_n), .acc_n(acc_n)
  );

  // quotient accumulates in x, product and remainder in acc
  assign fin = op_q == OP_MUL ? acc_n : op_q == OP_UDIV ? x_n : op_q == OP_UREM ? acc_n : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    state_d = accept ? S_RUN : last ? S_DONE : state_q == S_DONE ? S_IDLE : state_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= OP_MUL;
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      result_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      op_q <= op_e'(op);
      x_q <= operand_a;
      y_q <= operand_b;
      acc_q <= '0;
      cnt_q <= '0;
      addr_q <= dest_addr;
      dbz_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      x_q <= x_n;
      y_q <= y_n;
      acc_q <= acc_n;
      cnt_q <= cnt_q + 5'd1;
      if (last) begin
        result_q <= fin;
        dbz_q <= (op_q == OP_UDIV || op_q == OP_UREM) && y_q == '0;
      end
    end

  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign wb_enable = done && op_q != OP_RSVD;
  assign wb_addr = addr_q;
  assign result = result_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed vector table plus hand-written abort/overlap sequences
module tb_iter_muldiv;
  localparam int W = 32;
  localparam int A = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic [A-1:0] dest_addr = '0;
  logic busy, done, wb_enable, div_by_zero;
  logic [W-1:0] result;
  logic [A-1:0] wb_addr;
  int n_checks = 0, n_fail = 0;
  int lat, dcount, wbcount;
  bit gap;

  typedef struct {
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic [A-1:0] addr;
    logic [W-1:0] res;
    logic dbz, wb;
  } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  iter_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand_a(operand_a),
    .operand_b(operand_b), .dest_addr(dest_addr), .busy(busy), .done(done),
    .result(result), .wb_addr(wb_addr), .wb_enable(wb_enable), .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // caller sits just after a negedge; start is sampled on the next posedge
  task automatic run(input int idx, input vec_t v);
    int l = 0;
    bit g = 0;
    op = v.op; operand_a = v.a; operand_b = v.b; dest_addr = v.addr; start = 1'b1;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0; op = ~v.op; operand_a = ~v.a; operand_b = v.b + 1; dest_addr = ~v.addr;
      if (done) l = n;
      else if (!busy) g = 1;
    end
    check($sformatf("latency[%0d]", idx), l, 33);
    check($sformatf("busy_run[%0d]", idx), g, 0);
    if (l != 0) begin
      check($sformatf("result[%0d]", idx), result, v.res);
      check($sformatf("dbz[%0d]", idx), div_by_zero, v.dbz);
      check($sformatf("wb_en[%0d]", idx), wb_enable, v.wb);
      if (v.wb) check($sformatf("wb_addr[%0d]", idx), wb_addr, v.addr);
    end
    @(posedge clk); @(negedge clk);
    check($sformatf("done_pulse[%0d]", idx), {done, busy, wb_enable}, 3'b000);
    check($sformatf("result_hold[%0d]", idx), result, v.res);
    check($sformatf("dbz_hold[%0d]", idx), div_by_zero, v.dbz);
  endtask

  initial begin
    vecs = '{
      '{2'd0, 32'd7, 32'd6, 3'd3, 32'd42, 1'b0, 1'b1},
      '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h1, 1'b0, 1'b1},
      '{2'd1, 32'd100, 32'd7, 3'd2, 32'd14, 1'b0, 1'b1},
      '{2'd2, 32'd100, 32'd7, 3'd7, 32'd2, 1'b0, 1'b1},
      '{2'd1, 32'd5, 32'd0, 3'd4, 32'hFFFFFFFF, 1'b1, 1'b1},
      '{2'd2, 32'd5, 32'd0, 3'd5, 32'd5, 1'b1, 1'b1},
      '{2'd3, 32'd123, 32'd45, 3'd6, 32'd0, 1'b0, 1'b0},
      '{2'd0, 32'h10000, 32'h10000, 3'd0, 32'd0, 1'b0, 1'b1},
      '{2'd0, 32'd12345, 32'd678, 3'd1, 32'd8369910, 1'b0, 1'b1},
      '{2'd1, 32'hFFFFFFFF, 32'd1, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b1},
      '{2'd2, 32'hFFFFFFFF, 32'h10, 3'd3, 32'hF, 1'b0, 1'b1},
      '{2'd1, 32'd3, 32'd7, 3'd4, 32'd0, 1'b0, 1'b1},
      '{2'd1, 32'h80000000, 32'd3, 3'd5, 32'h2AAAAAAA, 1'b0, 1'b1},
      '{2'd2, 32'h80000000, 32'd3, 3'd6, 32'd2, 1'b0, 1'b1},
      '{2'd0, 32'd0, 32'hDEADBEEF, 3'd7, 32'd0, 1'b0, 1'b1}
    };
    #1;
    check("reset_outputs", {busy, done, wb_enable, div_by_zero}, 4'b0000);
    check("reset_result", result, 0);
    check("reset_wb_addr", wb_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) run(i, vecs[i]);

    // second start during RUN must be ignored
    op = 2'd0; operand_a = 32'd3; operand_b = 32'd4; dest_addr = 3'd5; start = 1'b1;
    lat = 0; dcount = 0; gap = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); @(negedge clk);
      start = (n == 10);
      if (n == 10) begin op = 2'd1; operand_a = 32'd9; operand_b = 32'd3; dest_addr = 3'd2; end
      if (done) begin dcount++; if (lat == 0) lat = n; end
      else if (n < 33 && !busy) gap = 1;
    end
    check("ovl_done_count", dcount, 1);
    check("ovl_latency", lat, 33);
    check("ovl_busy", gap, 0);
    check("ovl_result", result, 12);
    check("ovl_wb_addr", wb_addr, 5);

    // reset mid-RUN aborts without any writeback
    op = 2'd1; operand_a = 32'd100; operand_b = 32'd7; dest_addr = 3'd4; start = 1'b1;
    dcount = 0; wbcount = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (n == 10) begin
        rst = 1'b1;
        #1;
        check("abort_busy_now", busy, 0);
      end
      if (n == 11) rst = 1'b0;
      if (done) dcount++;
      if (wb_enable) wbcount++;
    end
    check("abort_done", dcount, 0);
    check("abort_wb", wbcount, 0);
    check("abort_result", result, 0);
    check("abort_wb_addr", wb_addr, 0);

    // start presented on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(99, '{2'd0, 32'd7, 32'd6, 3'd6, 32'd42, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
